// File: rtl/pc_fetch.sv
// Fetch stage: owns PCF, selects the next PC from PCSrc and runs a one-outstanding
// instruction-memory request/response FSM. Optional macro: PC_MISALIGN_CHK_EN.
module pc_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            StallF,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misaligned_f
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            ivalid_q, ivalid_d;
  logic            reqv_q, reqv_d;
  logic            drop_q, drop_d;
  logic            redirect;
  logic            handshake;
  logic            park;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

`ifdef PC_MISALIGN_CHK_EN
  logic mis_q, mis_d;
`endif

  assign redirect  = (PCSrc == 2'b01) || (PCSrc == 2'b10);
  assign target    = (PCSrc == 2'b10) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign handshake = reqv_q & imem_req_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ivalid_d = ivalid_q;
    drop_d   = drop_q;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;

      S_REQ: begin
        if (redirect) begin
          pc_d     = target;
          ivalid_d = 1'b0;
          if (handshake) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (handshake) begin
          state_d = S_WAIT;
        end
      end

      // A response coinciding with a redirect belongs to the old path, so it
      // is discarded directly instead of arming the drop flag.
      S_WAIT: begin
        if (redirect) begin
          pc_d     = target;
          ivalid_d = 1'b0;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d  = imem_rsp_data;
            ivalid_d = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d     = target;
          ivalid_d = 1'b0;
          state_d  = S_REQ;
        end else if (!StallF) begin
          pc_d     = pc_plus4;
          ivalid_d = 1'b0;
          state_d  = S_REQ;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

`ifdef PC_MISALIGN_CHK_EN
  // A misaligned redirect only suppresses req_valid; an outstanding request
  // still drains through S_WAIT so the FSM ends up parked in S_REQ.
  always_comb begin
    mis_d = mis_q;
    if (redirect && (state_q != S_BOOT)) begin
      mis_d = (target[1:0] != 2'b00);
    end
  end
  assign park = mis_d;
`else
  assign park = 1'b0;
`endif

  assign reqv_d = (state_d == S_REQ) && !park;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ivalid_q <= 1'b0;
      reqv_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      reqv_q   <= reqv_d;
      drop_q   <= drop_d;
`ifdef PC_MISALIGN_CHK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign imem_req_valid = reqv_q;
  assign imem_req_addr  = pc_q;
  assign PCF            = pc_q;
  assign PCPlus4F       = pc_plus4;
  assign InstrF         = instr_q;
  assign InstrValidF    = ivalid_q;
`ifdef PC_MISALIGN_CHK_EN
  assign misaligned_f   = mis_q;
`endif

endmodule
